// File: rtl/imm_pkg.sv
// Shared definitions for the immediate extender: mode encoding and a
// fixed-width reference extension function for decode-stage checkers.
package imm_pkg;

  typedef enum logic [1:0] {
    ZERO     = 2'b00,
    SIGN     = 2'b01,
    SIGN_SH1 = 2'b10,
    UPPER    = 2'b11
  } ext_mode_e;

  localparam int IMM_IN_W  = 9;
  localparam int IMM_OUT_W = 16;

  function automatic logic [IMM_OUT_W-1:0] ext_imm(input logic [IMM_IN_W-1:0] data,
                                                    input ext_mode_e mode);
    logic [IMM_OUT_W-1:0] sext;
    sext = {{(IMM_OUT_W-IMM_IN_W){data[IMM_IN_W-1]}}, data};
    case (mode)
      ZERO:     ext_imm = {{(IMM_OUT_W-IMM_IN_W){1'b0}}, data};
      SIGN:     ext_imm = sext;
      SIGN_SH1: ext_imm = {sext[IMM_OUT_W-2:0], 1'b0};
      default:  ext_imm = {data, {(IMM_OUT_W-IMM_IN_W){1'b0}}};
    endcase
  endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: zero, sign, sign-shift-by-1 or upper placement.
module imm_ext_core
  import imm_pkg::*;
#(
  parameter int IN_W  = 9,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  data_i,
  input  logic [1:0]       mode_i,
  output logic [OUT_W-1:0] data_o
);

  localparam int EXT_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sext;

  // Shifting the full sign extension keeps SIGN_SH1 legal when EXT_W is 1.
  assign sext = {{EXT_W{data_i[IN_W-1]}}, data_i};

  always_comb begin
    data_o = {{EXT_W{1'b0}}, data_i};
    case (ext_mode_e'(mode_i))
      ZERO:     data_o = {{EXT_W{1'b0}}, data_i};
      SIGN:     data_o = sext;
      SIGN_SH1: data_o = {sext[OUT_W-2:0], 1'b0};
      UPPER:    data_o = {data_i, {EXT_W{1'b0}}};
      default:  data_o = {{EXT_W{1'b0}}, data_i};
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Flow-controlled immediate extender: extension core feeding a DEPTH-entry
// FIFO with valid/ready on both sides and a synchronous flush.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int IN_W  = 9,
  parameter int OUT_W = 16,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          data_in,
  input  logic [1:0]               mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  if ((OUT_W < IN_W + 1) || (IN_W < 2) || (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_param_check
    $error("imm_extend_pipe: illegal IN_W/OUT_W/DEPTH combination");
  end

  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [OUT_W-1:0] ext_data;
  logic             push, pop;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .data_i (data_in),
    .mode_i (mode),
    .data_o (ext_data)
  );

  // Flags come only from registered level, so out_ready never reaches in_ready.
  assign in_ready  = (level_q != FULL_LVL);
  assign out_valid = (level_q != '0);
  assign data_out  = mem_q[rd_ptr_q];
  assign level     = level_q;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is cleared by reset but deliberately kept across flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= ext_data;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: expected results queued on accepted
// pushes and compared when the FIFO head is popped.
`timescale 1ns/1ps
module tb_imm_extend_pipe;

  localparam int IN_W  = 9;
  localparam int OUT_W = 16;
  localparam int DEPTH = 2;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  data_in = '0;
  logic [1:0]       mode = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] data_out;
  logic [LVL_W-1:0] level;

  int checks = 0;
  int errors = 0;
  logic [OUT_W-1:0] sb_q[$];

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Arithmetic reference model, written independently of the RTL structure.
  function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] d, input logic [1:0] m);
    int unsigned v, hi_mask, all_mask;
    all_mask = (1 << OUT_W) - 1;
    hi_mask  = all_mask & ~((1 << IN_W) - 1);
    v = d;
    if (d[IN_W-1]) v = v | hi_mask;
    case (m)
      2'd0:    return OUT_W'(d);
      2'd1:    return OUT_W'(v);
      2'd2:    return OUT_W'((v << 1) & all_mask);
      default: return OUT_W'((d << (OUT_W - IN_W)) & all_mask);
    endcase
  endfunction

  // Samples 4ns after the falling edge, 1ns before the rising edge that acts.
  always begin
    @(negedge clk);
    #4;
    if (rst_n && flush) begin
      sb_q.delete();
      $display("flush level=%0d", level);
    end else if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_val("pop_unexpected", 32'(data_out), 32'hFFFF_FFFF);
        end else begin
          logic [OUT_W-1:0] e;
          e = sb_q.pop_front();
          $display("pop data_out=%h expected=%h", data_out, e);
          check_val("pop_data", 32'(data_out), 32'(e));
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(data_in, mode));
        $display("push data_in=%h mode=%0d", data_in, mode);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [IN_W-1:0] d, input logic [1:0] m, input logic rdy);
    in_valid  = v;
    data_in   = d;
    mode      = m;
    out_ready = rdy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [OUT_W-1:0] mode_tbl [4];
    mode_tbl[0] = 16'h0111;
    mode_tbl[1] = 16'hFF11;
    mode_tbl[2] = 16'hFE22;
    mode_tbl[3] = 16'h8880;

    #3;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_level", 32'(level), 32'd0);
    check_val("rst_data_out", 32'(data_out), 32'd0);
    #4 rst_n = 1'b1;

    // Single-cycle latency, sign then small positive value
    step(); drive(1'b1, 9'h100, 2'd1, 1'b0);
    step(); drive(1'b0, '0, 2'd0, 1'b1);
    check_val("lat_out_valid", 32'(out_valid), 32'd1);
    check_val("lat_sign_100", 32'(data_out), 32'hFF00);
    check_val("lat_level", 32'(level), 32'd1);
    step(); drive(1'b1, 9'h00C, 2'd1, 1'b0);
    step(); drive(1'b0, '0, 2'd0, 1'b1);
    check_val("sign_00c", 32'(data_out), 32'h000C);
    step();

    // All modes on 9'h111 with the consumer always ready
    for (int m = 0; m < 4; m++) begin
      step();
      if (m > 0) check_val("mode_tbl", 32'(data_out), 32'(mode_tbl[m-1]));
      drive(1'b1, 9'h111, 2'(m), 1'b1);
    end
    step(); check_val("mode_tbl_upper", 32'(data_out), 32'(mode_tbl[3]));
    drive(1'b0, '0, 2'd0, 1'b1);
    step(); check_val("modes_drained", 32'(level), 32'd0);

    // Fill to DEPTH with consumer stalled, refuse a third push, then drain
    drive(1'b1, 9'h001, 2'd0, 1'b0);
    step(); drive(1'b1, 9'h002, 2'd0, 1'b0);
    step(); drive(1'b1, 9'h003, 2'd0, 1'b0);
    step();
    check_val("full_level", 32'(level), 32'd2);
    check_val("full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b0, '0, 2'd0, 1'b1);
    check_val("full_head", 32'(data_out), 32'h0001);
    step(); check_val("drain_level1", 32'(level), 32'd1);
    check_val("drain_in_ready", 32'(in_ready), 32'd1);
    step();
    check_val("drain_level0", 32'(level), 32'd0);
    check_val("drain_out_valid", 32'(out_valid), 32'd0);
    check_val("wrap_rd_ptr", 32'(dut.rd_ptr_q), 32'd0);
    check_val("wrap_wr_ptr", 32'(dut.wr_ptr_q), 32'd0);

    // Streaming: simultaneous push and pop every cycle
    for (int i = 0; i < 8; i++) begin
      if (i > 0) check_val("stream_level", 32'(level), 32'd1);
      drive(1'b1, 9'((i * 37 + 5) ^ (i << 6)), 2'(i % 4), 1'b1);
      step();
    end
    drive(1'b0, '0, 2'd0, 1'b1);
    check_val("stream_tail_level", 32'(level), 32'd1);
    step(); check_val("stream_empty", 32'(level), 32'd0);

    // Flush while full with a push presented
    drive(1'b1, 9'h0AA, 2'd0, 1'b0);
    step(); drive(1'b1, 9'h0BB, 2'd1, 1'b0);
    step(); check_val("pre_flush_level", 32'(level), 32'd2);
    flush = 1'b1; drive(1'b1, 9'h0CC, 2'd0, 1'b1);
    step(); flush = 1'b0; drive(1'b0, '0, 2'd0, 1'b0);
    check_val("flush_level", 32'(level), 32'd0);
    check_val("flush_out_valid", 32'(out_valid), 32'd0);
    check_val("flush_in_ready", 32'(in_ready), 32'd1);
    // Flush with one entry buffered drops the push presented alongside it
    drive(1'b1, 9'h0DD, 2'd0, 1'b0);
    step(); flush = 1'b1; drive(1'b1, 9'h0EE, 2'd0, 1'b0);
    step(); flush = 1'b0; drive(1'b0, '0, 2'd0, 1'b0);
    check_val("flush_drop_level", 32'(level), 32'd0);
    drive(1'b1, 9'h1F0, 2'd3, 1'b0);
    step(); drive(1'b0, '0, 2'd0, 1'b1);
    check_val("post_flush_data", 32'(data_out), 32'hF800);
    step(); check_val("post_flush_empty", 32'(level), 32'd0);

    // Asynchronous reset pulse between edges while holding one entry
    drive(1'b1, 9'h0F0, 2'd0, 1'b0);
    step(); drive(1'b0, '0, 2'd0, 1'b0);
    check_val("pre_rst_level", 32'(level), 32'd1);
    #1 rst_n = 1'b0;
    sb_q.delete();
    #0.5;
    check_val("arst_out_valid", 32'(out_valid), 32'd0);
    check_val("arst_data_out", 32'(data_out), 32'd0);
    check_val("arst_level", 32'(level), 32'd0);
    check_val("arst_in_ready", 32'(in_ready), 32'd1);
    #0.5 rst_n = 1'b1;
    step(); drive(1'b1, 9'h1FF, 2'd1, 1'b0);
    step(); drive(1'b0, '0, 2'd0, 1'b1);
    check_val("rst_push_entry0", 32'(dut.wr_ptr_q), 32'd1);
    check_val("rst_push_data", 32'(data_out), 32'hFFFF);
    step(); drive(1'b0, '0, 2'd0, 1'b0);
    check_val("final_level", 32'(level), 32'd0);
    check_val("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, flow-controlled immediate extender for the datapath front end. It accepts an IN_W-bit immediate together with a per-transfer mode, and extends it to OUT_W bits by zero-extension, sign-extension, sign-extension with a left shift of 1, or upper placement. Results are buffered in a DEPTH-entry FIFO with valid/ready handshakes on both sides. It supersedes the fixed 9-to-16-bit sign extender between instruction decode and the ALU operand mux.

## Interface
- IN_W, default 9: immediate input width; must be at least 2.
- OUT_W, default 16: extended output width; must be at least IN_W+1.
- DEPTH, default 2: FIFO entries; power of two, at least 2.
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- flush, input, 1: synchronous clear of all buffered entries.
- in_valid, input, 1: data_in and mode are valid.
- in_ready, output, 1: block can accept a transfer.
- data_in, input, IN_W: raw immediate.
- mode, input, 2: extension mode, encoded as follows.
  - 00 ZERO: zero-extend.
  - 01 SIGN: sign-extend.
  - 10 SIGN_SH1: sign-extend, then shift left by 1.
  - 11 UPPER: data_in in the top IN_W bits, zeros below.
- out_valid, output, 1: data_out holds a valid result.
- out_ready, input, 1: consumer accepts data_out.
- data_out, output, OUT_W: extended result at the FIFO head.
- level, output, clog2(DEPTH)+1: current occupancy, 0..DEPTH.

## Operation
- Push occurs when in_valid && in_ready at a rising edge. The extended result is computed combinationally from data_in and mode, then written to mem[wr_ptr].
- Pop occurs when out_valid && out_ready at a rising edge. rd_ptr advances.
- Extension rules, with s = data_in[IN_W-1]:
  - ZERO: {(OUT_W-IN_W) zeros, data_in}.
  - SIGN: {(OUT_W-IN_W) copies of s, data_in}.
  - SIGN_SH1: {(OUT_W-IN_W-1) copies of s, data_in, 1'b0}. No bits are lost, because OUT_W is at least IN_W+1.
  - UPPER: {data_in, (OUT_W-IN_W) zeros}.
- Flag logic:
  - in_ready = (level != DEPTH) and is registered-state-derived. There is no combinational path from out_ready to in_ready.
  - out_valid = (level != 0).
  - data_out = mem[rd_ptr] at all times. When the FIFO is empty, data_out shows the stale or reset entry.
- Pointers are clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Simultaneous push and pop: legal when level is between 1 and DEPTH-1, and level is unchanged. When level is 0, only the push happens, because out_valid is low. When level is DEPTH, only the pop happens, because in_ready is low.
- flush has priority over push and pop in the same cycle. It sets level, wr_ptr and rd_ptr to 0, drops any push presented that cycle, and does not clear mem.
- Reset (rst_n low) clears the following immediately, without waiting for a clock edge:
  - level, wr_ptr and rd_ptr are set to 0.
  - every mem entry is set to 0.
  - resulting outputs: out_valid 0, in_ready 1, data_out 0, level 0.
- Reset asserted mid-transfer discards all buffered data. The first accepted push after rst_n deasserts lands in entry 0.

## Timing
- Latency is 1 cycle: a push at edge N gives out_valid=1 and the new data_out after edge N, provided the FIFO was empty.
- Throughput is one transfer per cycle in steady state when out_ready is held high.
- With out_ready held low, exactly DEPTH pushes are accepted. in_ready falls after the DEPTH-th push edge.
- in_ready rises in the cycle after the first pop from full. The push can therefore resume one edge later.
- flush at edge N gives out_valid=0 and in_ready=1 after N.
- data_in and mode must be stable only while in_valid is high at the sampling edge.
- A producer must hold data_in and mode stable while in_valid is high and in_ready is low.

## Structure
- Shared package imm_pkg holds:
  - typedef ext_mode_e, a 2-bit enum with ZERO, SIGN, SIGN_SH1 and UPPER.
  - function ext_imm(data, mode) for reuse by decode-stage checkers.
- One combinational sub-module, imm_ext_core (IN_W, OUT_W), computes the extension.
- The top level holds the FIFO storage, pointers, level and handshake logic.
- Parameter legality (OUT_W at least IN_W+1, DEPTH a power of two) is checked by an elaboration-time assertion.

## Test plan
- Reset then mode SIGN, data_in=9'h100 -> data_out=16'hFF00, out_valid=1 one cycle after the push. Then data_in=9'h00C -> 16'h000C.
- All modes on data_in=9'h111 -> ZERO gives 16'h0111, SIGN gives 16'hFF11, SIGN_SH1 gives 16'hFE22, UPPER gives 16'h8880.
- Fill with out_ready=0 and pushes 9'h001 and 9'h002 -> level=2, in_ready=0, third push refused. Drain -> outputs 16'h0001 then 16'h0002 in order, pointers wrap to 0.
- Continuous stream of 8 values with out_ready=1 and simultaneous push/pop -> one output per cycle, level stays at 1, order preserved.
- flush while level=2 and a push is presented -> level=0, out_valid=0, the pushed value never appears.
- rst_n pulsed low between clock edges while level=1 -> out_valid=0 and data_out=0 immediately. The next push lands in entry 0 and is output correctly.
